// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : Prescaled LED pattern generator (rotate left/right, bounce,
//               blink) with one-cycle preload strobe and tick-aligned step.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             dir
);

    localparam logic [1:0] c_MODE_ROL   = 2'b00;
    localparam logic [1:0] c_MODE_ROR   = 2'b01;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b10;
    localparam logic [1:0] c_MODE_BLINK = 2'b11;

    localparam logic [DIV_W-1:0] c_CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_LED_RST = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_led;
    logic             r_dir;
    logic             r_step;

    logic             w_tick;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_led_nxt;
    logic             w_dir_nxt;

    // The >= compare (rather than ==) lets a lowered div force a prompt tick
    // and keeps the counter from ever wrapping.
    assign w_tick = en && (r_cnt >= div);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_tick) begin
            w_cnt_nxt = '0;
        end else if (en) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
    end

    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir;
        if (w_tick) begin
            case (mode)
                c_MODE_ROL: w_led_nxt = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
                c_MODE_ROR: w_led_nxt = {r_led[0], r_led[WIDTH-1:1]};
                c_MODE_BOUNCE: begin
                    // An all-zero pattern has nothing to bounce; keep dir.
                    if (r_led != '0) begin
                        if (!r_dir && r_led[WIDTH-1]) begin
                            w_dir_nxt = 1'b1;
                            w_led_nxt = r_led >> 1;
                        end else if (r_dir && r_led[0]) begin
                            w_dir_nxt = 1'b0;
                            w_led_nxt = r_led << 1;
                        end else if (r_dir) begin
                            w_led_nxt = r_led >> 1;
                        end else begin
                            w_led_nxt = r_led << 1;
                        end
                    end
                end
                c_MODE_BLINK: w_led_nxt = ~r_led;
                default:      w_led_nxt = r_led;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led  <= c_LED_RST;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_step <= 1'b0;
        end else if (load) begin
            r_led  <= load_val;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_step <= 1'b0;
        end else begin
            r_led  <= w_led_nxt;
            r_cnt  <= w_cnt_nxt;
            r_dir  <= w_dir_nxt;
            r_step <= w_tick;
        end
    end

    assign led  = r_led;
    assign step = r_step;
    assign dir  = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Directed plus randomized bench for led_pattern_gen against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int WIDTH = 16;
    localparam int DIV_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [DIV_W-1:0] div;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] led;
    logic             step;
    logic             dir;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [DIV_W-1:0] m_cnt;
    logic [WIDTH-1:0] m_led;
    logic             m_dir;
    logic             m_step;

    led_pattern_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div      (div),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .led      (led),
        .step     (step),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the model by one clock from the currently applied inputs.
    task automatic model_update();
        logic tick;
        logic at_end;
        if (!rst_n) begin
            m_led = 1; m_cnt = 0; m_dir = 0; m_step = 0;
        end else if (load) begin
            m_led = load_val; m_cnt = 0; m_dir = 0; m_step = 0;
        end else begin
            tick   = en && (m_cnt >= div);
            m_step = tick;
            if (tick)    m_cnt = 0;
            else if (en) m_cnt = m_cnt + 1;
            if (tick) begin
                case (mode)
                    2'd0: m_led = (m_led << 1) | (m_led >> (WIDTH - 1));
                    2'd1: m_led = (m_led >> 1) | (m_led << (WIDTH - 1));
                    2'd2: if (m_led != 0) begin
                        at_end = m_dir ? m_led[0] : m_led[WIDTH-1];
                        if (at_end) m_dir = !m_dir;
                        m_led = m_dir ? (m_led >> 1) : (m_led << 1);
                    end
                    default: m_led = ~m_led;
                endcase
            end
        end
    endtask

    task automatic cyc();
        model_update();
        @(posedge clk);
        #1;
        chk("led",  32'(led),  32'(m_led));
        chk("step", 32'(step), 32'(m_step));
        chk("dir",  32'(dir),  32'(m_dir));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        m_cnt = 0; m_led = 0; m_dir = 0; m_step = 0;
        rst_n = 1'b0; en = 1'b1; div = 5; mode = 2'b00; load = 1'b0; load_val = '0;
        @(negedge clk);

        // Reset and default rotate left
        run(2);
        chk("rst_led", 32'(led), 32'h0001);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        rst_n = 1'b1;
        run(6);
        chk("rol_first", 32'(led), 32'h0002);
        chk("rol_step", 32'(step), 32'h1);
        run(14 * 6);
        chk("rol_msb", 32'(led), 32'h8000);
        run(6);
        chk("rol_wrap", 32'(led), 32'h0001);

        // Enable gating: en toggles every cycle
        for (int i = 0; i < 30; i++) begin
            en = (i % 2) == 0;
            cyc();
            if (!en) chk("gated_step", 32'(step), 32'h0);
        end
        en = 1'b1;

        // Bounce from reset, div = 0
        rst_n = 1'b0; mode = 2'b10; div = 0;
        cyc();
        rst_n = 1'b1;
        run(15);
        chk("bnc_top", 32'(led), 32'h8000);
        run(1);
        chk("bnc_rev", 32'(led), 32'h4000);
        chk("bnc_dir1", 32'(dir), 32'h1);
        run(14);
        chk("bnc_bot", 32'(led), 32'h0001);
        run(1);
        chk("bnc_back", 32'(led), 32'h0002);
        chk("bnc_dir0", 32'(dir), 32'h0);

        // Load coincident with a due tick
        mode = 2'b01; div = 3;
        for (int i = 0; i < 8 && m_cnt < div; i++) cyc();
        load = 1'b1; load_val = 16'h00F0;
        cyc();
        load = 1'b0;
        chk("ld_led", 32'(led), 32'h00F0);
        chk("ld_step", 32'(step), 32'h0);
        run(3);
        chk("ld_hold", 32'(led), 32'h00F0);
        run(1);
        chk("ld_ror", 32'(led), 32'h0078);

        // Blink, then switch to rotate mid-period
        load = 1'b1; load_val = 16'hAAAA; mode = 2'b11;
        cyc();
        load = 1'b0;
        run(4);
        chk("blink1", 32'(led), 32'h5555);
        run(2);
        mode = 2'b00;
        run(2);
        chk("blink_rol", 32'(led), 32'hAAAA);
        chk("blink_step", 32'(step), 32'h1);

        // Reset mid-bounce with dir = 1, then lower div below cnt
        load = 1'b1; load_val = 16'h8000; mode = 2'b10; div = 4;
        cyc();
        load = 1'b0;
        run(5 + 3);
        chk("mid_dir", 32'(dir), 32'h1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mid_rst_led", 32'(led), 32'h0001);
        chk("mid_rst_dir", 32'(dir), 32'h0);
        div = 9;
        run(7);
        chk("pre_div_step", 32'(step), 32'h0);
        div = 2;
        run(1);
        chk("div_drop_tick", 32'(step), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            mode     = 2'($urandom_range(0, 3));
            load     = ($urandom_range(0, 19) == 0);
            load_val = 16'($urandom);
            rst_n    = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 15) == 0) div = $urandom_range(0, 12);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
